// File: rtl/shifter_pkg.sv
// Package: shifter_pkg
// Shared types for the pipelined shift unit.
//   shift_op_e   : shift operation encoding (00 LSL, 01 LSR, 10 ASR, 11 ROR)
//   stage_ctrl_t : per-stage control payload carried alongside data and amount
// Optional feature macro: SHIFT_FLAGS_EN (adds the carry bit to the stage payload).
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Data and amount widths depend on the WIDTH parameter, so they travel as separate
  // vectors; the width-independent part of the payload lives here.
  typedef struct packed {
    shift_op_e op;
`ifdef SHIFT_FLAGS_EN
    logic      carry;
`endif
  } stage_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// Module: shift_stage
// One level of the pipelined shifter: shifts by 2**LEVEL when amount[LEVEL] is set, then
// registers the payload behind a valid/ready handshake.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready = !valid || out_ready)
//   in_data/in_amount/in_ctrl   incoming payload
//   out_valid/out_ready         downstream handshake
//   out_data/out_amount/out_ctrl registered payload
// Optional feature macro: SHIFT_FLAGS_EN (tracks the carry bit).
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned LEVEL   = 0,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  stage_ctrl_t        in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_amount,
  output stage_ctrl_t        out_ctrl
);

  localparam int unsigned Dist = 2 ** LEVEL;

  logic               valid_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] amount_q;
  stage_ctrl_t        ctrl_q, ctrl_d;

  always_comb begin
    data_d = in_data;
    ctrl_d = in_ctrl;
    if (in_amount[LEVEL]) begin
      unique case (in_ctrl.op)
        SH_LSL: data_d = in_data << Dist;
        SH_LSR: data_d = in_data >> Dist;
        SH_ASR: data_d = $signed(in_data) >>> Dist;
        SH_ROR: data_d = (in_data >> Dist) | (in_data << (WIDTH - Dist));
      endcase
`ifdef SHIFT_FLAGS_EN
      // Carry is the last bit to leave the word; for ROR it is the new MSB.
      if (in_ctrl.op == SH_LSL) begin
        ctrl_d.carry = in_data[WIDTH-Dist];
      end else if (in_ctrl.op == SH_ROR) begin
        ctrl_d.carry = data_d[WIDTH-1];
      end else begin
        ctrl_d.carry = in_data[Dist-1];
      end
`endif
    end
  end

  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amount_q <= '0;
      ctrl_q   <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      // Payload only moves with a real operation; bubbles leave it untouched.
      if (in_valid) begin
        data_q   <= data_d;
        amount_q <= in_amount;
        ctrl_q   <= ctrl_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_amount = amount_q;
  assign out_ctrl   = ctrl_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Module: pipelined_shifter
// Fully pipelined LSL/LSR/ASR/ROR unit, one register per log2(WIDTH) mux level, with
// valid/ready on both sides. Latency SHAMT_W cycles, throughput one op per cycle.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready combinational from out_ready)
//   in_data/in_amount     operand and shift amount
//   in_op                 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid/out_ready   output handshake
//   out_data              shifted result
//   out_carry, out_zero   flags; tied to 0 unless SHIFT_FLAGS_EN is defined
// Optional feature macro: SHIFT_FLAGS_EN.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH   = 16,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero
);

  // Index k is the input of stage k; index SHAMT_W is the output of the last stage.
  logic               valid  [SHAMT_W+1];
  logic               ready  [SHAMT_W+1];
  logic [WIDTH-1:0]   data   [SHAMT_W+1];
  logic [SHAMT_W-1:0] amount [SHAMT_W+1];
  stage_ctrl_t        ctrl   [SHAMT_W+1];
  stage_ctrl_t        ctrl_in;

  always_comb begin
    ctrl_in    = '0;
    ctrl_in.op = shift_op_e'(in_op);
  end

  assign valid[0]        = in_valid;
  assign in_ready        = ready[0];
  assign data[0]         = in_data;
  assign amount[0]       = in_amount;
  assign ctrl[0]         = ctrl_in;
  assign ready[SHAMT_W]  = out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .LEVEL (k)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (valid[k]),
      .in_ready   (ready[k]),
      .in_data    (data[k]),
      .in_amount  (amount[k]),
      .in_ctrl    (ctrl[k]),
      .out_valid  (valid[k+1]),
      .out_ready  (ready[k+1]),
      .out_data   (data[k+1]),
      .out_amount (amount[k+1]),
      .out_ctrl   (ctrl[k+1])
    );
  end

  assign out_valid = valid[SHAMT_W];
  assign out_data  = data[SHAMT_W];

`ifdef SHIFT_FLAGS_EN
  assign out_carry = ctrl[SHAMT_W].carry;
  // Derived from the last-stage register; gated so it reads 0 while no result is held.
  assign out_zero  = valid[SHAMT_W] && (data[SHAMT_W] == '0);
`else
  assign out_carry = 1'b0;
  assign out_zero  = 1'b0;
`endif

  // The fully consumed amount and op are not needed past the last stage.
  logic unused_tail;
  assign unused_tail = ^{amount[SHAMT_W], ctrl[SHAMT_W].op};

endmodule
